// File: rtl/microseq_ctrl_if.sv
// Bus between the microcode sequencer and its environment: instruction/flag
// inputs from the CPU core and the decoded control word going back out.
interface microseq_ctrl_if #(
  parameter int STEP_W = 3
);
  logic              ena;
  logic [3:0]        opcode;
  logic              flag_c;
  logic              flag_z;
  logic              resume;
  logic [14:0]       ctrl_out;
  logic [STEP_W-1:0] step;
  logic              instr_done;
  logic              halted;

  modport master (
    output ena, opcode, flag_c, flag_z, resume,
    input  ctrl_out, step, instr_done, halted
  );

  modport slave (
    input  ena, opcode, flag_c, flag_z, resume,
    output ctrl_out, step, instr_done, halted
  );
endinterface

// File: rtl/microseq_ctrl.sv
// T-state microcode sequencer for the 8-bit CPU: early instruction end,
// conditional jumps on carry/zero, latched halt with resume, and an enable gate.
module microseq_ctrl #(
  parameter int T_STATES  = 6,
  parameter bit EARLY_END = 1'b1
) (
  input logic           clk,
  input logic           rst_n,
  microseq_ctrl_if.slave bus
);
  localparam int STEP_W = $clog2(T_STATES);
  localparam logic [STEP_W-1:0] STEP_MAX = STEP_W'(T_STATES - 1);

  typedef enum logic [0:0] {
    ST_RUN    = 1'b0,
    ST_HALTED = 1'b1
  } state_e;

  state_e            state_q, state_d;
  logic [STEP_W-1:0] step_q, step_d;
  logic              last_s;
  logic              hlt_s;
  logic [14:0]       ctrl_s;
  logic              done_s;

  // Index of the final microstep of each opcode (length - 1).
  function automatic logic [STEP_W-1:0] last_step(input logic [3:0] op);
    logic [STEP_W-1:0] l;
    case (op)
      4'h1, 4'h4:                             l = STEP_W'(3);
      4'h2, 4'h3:                             l = STEP_W'(4);
      4'h5, 4'h6, 4'h7, 4'h8, 4'hE, 4'hF:     l = STEP_W'(2);
      default:                                l = STEP_W'(1);
    endcase
    return l;
  endfunction

  // Control word for a given step in RUN; anything past an instruction's end is 0.
  function automatic logic [14:0] step_word(input logic [3:0] op, input logic [STEP_W-1:0] st,
                                            input logic c, input logic z);
    logic [14:0] w;
    case (st)
      STEP_W'(0): w = 15'h2002;
      STEP_W'(1): w = 15'h0A04;
      STEP_W'(2): begin
        case (op)
          4'h1, 4'h2, 4'h3, 4'h4: w = 15'h2400;
          4'h5:    w = 15'h0500;
          4'h6:    w = 15'h0401;
          4'h7:    w = c ? 15'h0401 : 15'h0000;
          4'h8:    w = z ? 15'h0401 : 15'h0000;
          4'hE:    w = 15'h0088;
          4'hF:    w = 15'h4000;
          default: w = 15'h0000;
        endcase
      end
      STEP_W'(3): begin
        case (op)
          4'h1:       w = 15'h0900;
          4'h2, 4'h3: w = 15'h0810;
          4'h4:       w = 15'h1080;
          default:    w = 15'h0000;
        endcase
      end
      STEP_W'(4): begin
        case (op)
          4'h2:    w = 15'h0140;
          4'h3:    w = 15'h0160;
          default: w = 15'h0000;
        endcase
      end
      default: w = 15'h0000;
    endcase
    return w;
  endfunction

  assign last_s = EARLY_END ? (step_q == last_step(bus.opcode)) : (step_q == STEP_MAX);
  assign hlt_s  = (state_q == ST_RUN) && (step_q == STEP_W'(2)) && (bus.opcode == 4'hF);

  // State and step registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_RUN;
      step_q  <= '0;
    end else begin
      state_q <= state_d;
      step_q  <= step_d;
    end
  end

  // Next-state: ena low freezes everything; HLT wins over the early-end wrap.
  always_comb begin
    state_d = state_q;
    step_d  = step_q;
    if (!bus.ena) begin
      state_d = state_q;
      step_d  = step_q;
    end else if (state_q == ST_HALTED) begin
      if (bus.resume) begin
        state_d = ST_RUN;
        step_d  = '0;
      end else begin
        state_d = ST_HALTED;
        step_d  = '0;
      end
    end else if (hlt_s) begin
      state_d = ST_HALTED;
      step_d  = '0;
    end else if (last_s) begin
      state_d = ST_RUN;
      step_d  = '0;
    end else begin
      state_d = ST_RUN;
      step_d  = step_q + STEP_W'(1);
    end
  end

  // Output decode, gated off during reset and while disabled.
  always_comb begin
    ctrl_s = 15'h0000;
    done_s = 1'b0;
    if (!rst_n || !bus.ena) begin
      ctrl_s = 15'h0000;
      done_s = 1'b0;
    end else if (state_q == ST_HALTED) begin
      ctrl_s = 15'h4000;
      done_s = 1'b0;
    end else begin
      ctrl_s = step_word(bus.opcode, step_q, bus.flag_c, bus.flag_z);
      done_s = last_s;
    end
  end

  assign bus.ctrl_out   = ctrl_s;
  assign bus.instr_done = done_s;
  assign bus.step       = step_q;
  assign bus.halted     = (state_q == ST_HALTED);
endmodule

// File: tb/tb_microseq_ctrl.sv
// Scoreboard bench for microseq_ctrl: one early-end instance and one legacy-timing
// instance share stimulus; each cycle's expected outputs are queued and checked.
module tb_microseq_ctrl;
  localparam int N = 0;
  localparam int A = 1;
  localparam int B = 2;

  typedef struct {
    int          sel;
    logic [14:0] ctrl;
    logic [2:0]  step;
    logic        done;
    logic        halt;
  } exp_t;

  logic clk;
  logic rst_n;
  exp_t sb_q[$];
  int   n_total;
  int   n_pass;

  microseq_ctrl_if #(.STEP_W(3)) ifa ();
  microseq_ctrl_if #(.STEP_W(3)) ifb ();

  microseq_ctrl #(.T_STATES(6), .EARLY_END(1'b1)) dut_a (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (ifa)
  );

  microseq_ctrl #(.T_STATES(6), .EARLY_END(1'b0)) dut_b (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (ifb)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One cycle: apply inputs just after the edge and queue the outputs expected in that cycle.
  task automatic r(input int sel, input logic rst, input logic en, input logic [3:0] op,
                   input logic c, input logic z, input logic res,
                   input logic [14:0] ec, input logic [2:0] es, input logic ed, input logic eh);
    exp_t e;
    @(posedge clk);
    #1;
    rst_n      = rst;
    ifa.ena    = en;  ifb.ena    = en;
    ifa.opcode = op;  ifb.opcode = op;
    ifa.flag_c = c;   ifb.flag_c = c;
    ifa.flag_z = z;   ifb.flag_z = z;
    ifa.resume = res; ifb.resume = res;
    if (sel != N) begin
      e.sel  = sel;
      e.ctrl = ec;
      e.step = es;
      e.done = ed;
      e.halt = eh;
      sb_q.push_back(e);
    end else begin
      e.sel = N;
    end
  endtask

  // Monitor: on the falling edge compare whatever the stimulus queued for this cycle.
  always @(negedge clk) begin
    exp_t        e;
    logic [14:0] gc;
    logic [2:0]  gs;
    logic        gd;
    logic        gh;
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      if (e.sel == A) begin
        gc = ifa.ctrl_out; gs = ifa.step; gd = ifa.instr_done; gh = ifa.halted;
      end else begin
        gc = ifb.ctrl_out; gs = ifb.step; gd = ifb.instr_done; gh = ifb.halted;
      end
      n_total = n_total + 1;
      if (gc === e.ctrl && gs === e.step && gd === e.done && gh === e.halt) begin
        n_pass = n_pass + 1;
      end else begin
        $display("FAIL cyc%0d dut%0d: got ctrl=%h step=%0d done=%b halt=%b, want ctrl=%h step=%0d done=%b halt=%b",
                 n_total, e.sel, gc, gs, gd, gh, e.ctrl, e.step, e.done, e.halt);
      end
    end
  end

  initial begin
    n_total = 0;
    n_pass  = 0;
    rst_n = 1'b0;
    ifa.ena = 1'b1; ifb.ena = 1'b1;
    ifa.opcode = 4'h0; ifb.opcode = 4'h0;
    ifa.flag_c = 1'b0; ifb.flag_c = 1'b0;
    ifa.flag_z = 1'b0; ifb.flag_z = 1'b0;
    ifa.resume = 1'b0; ifb.resume = 1'b0;

    // Reset held, then LDA with a stray resume in RUN
    r(A, 1'b0, 1'b1, 4'h1, 1'b0, 1'b0, 1'b0, 15'h0000, 3'd0, 1'b0, 1'b0);
    r(A, 1'b1, 1'b1, 4'h1, 1'b0, 1'b0, 1'b0, 15'h2002, 3'd0, 1'b0, 1'b0);
    r(A, 1'b1, 1'b1, 4'h1, 1'b0, 1'b0, 1'b1, 15'h0A04, 3'd1, 1'b0, 1'b0);
    r(A, 1'b1, 1'b1, 4'h1, 1'b0, 1'b0, 1'b0, 15'h2400, 3'd2, 1'b0, 1'b0);
    r(A, 1'b1, 1'b1, 4'h1, 1'b0, 1'b0, 1'b0, 15'h0900, 3'd3, 1'b1, 1'b0);
    // JC not taken (zero flag set must not matter), then taken
    r(A, 1'b1, 1'b1, 4'h7, 1'b0, 1'b0, 1'b0, 15'h2002, 3'd0, 1'b0, 1'b0);
    r(A, 1'b1, 1'b1, 4'h7, 1'b0, 1'b0, 1'b0, 15'h0A04, 3'd1, 1'b0, 1'b0);
    r(A, 1'b1, 1'b1, 4'h7, 1'b0, 1'b1, 1'b0, 15'h0000, 3'd2, 1'b1, 1'b0);
    r(A, 1'b1, 1'b1, 4'h7, 1'b1, 1'b0, 1'b0, 15'h2002, 3'd0, 1'b0, 1'b0);
    r(A, 1'b1, 1'b1, 4'h7, 1'b1, 1'b0, 1'b0, 15'h0A04, 3'd1, 1'b0, 1'b0);
    r(A, 1'b1, 1'b1, 4'h7, 1'b1, 1'b0, 1'b0, 15'h0401, 3'd2, 1'b1, 1'b0);
    // JZ not taken (carry set must not matter), then taken
    r(A, 1'b1, 1'b1, 4'h8, 1'b1, 1'b0, 1'b0, 15'h2002, 3'd0, 1'b0, 1'b0);
    r(A, 1'b1, 1'b1, 4'h8, 1'b1, 1'b0, 1'b0, 15'h0A04, 3'd1, 1'b0, 1'b0);
    r(A, 1'b1, 1'b1, 4'h8, 1'b1, 1'b0, 1'b0, 15'h0000, 3'd2, 1'b1, 1'b0);
    r(A, 1'b1, 1'b1, 4'h8, 1'b0, 1'b1, 1'b0, 15'h2002, 3'd0, 1'b0, 1'b0);
    r(A, 1'b1, 1'b1, 4'h8, 1'b0, 1'b1, 1'b0, 15'h0A04, 3'd1, 1'b0, 1'b0);
    r(A, 1'b1, 1'b1, 4'h8, 1'b0, 1'b1, 1'b0, 15'h0401, 3'd2, 1'b1, 1'b0);
    // NOP, LDI, OUT, opcode A as NOP, STA, SUB
    r(A, 1'b1, 1'b1, 4'h0, 1'b0, 1'b0, 1'b0, 15'h2002, 3'd0, 1'b0, 1'b0);
    r(A, 1'b1, 1'b1, 4'h0, 1'b0, 1'b0, 1'b0, 15'h0A04, 3'd1, 1'b1, 1'b0);
    r(A, 1'b1, 1'b1, 4'h5, 1'b0, 1'b0, 1'b0, 15'h2002, 3'd0, 1'b0, 1'b0);
    r(A, 1'b1, 1'b1, 4'h5, 1'b0, 1'b0, 1'b0, 15'h0A04, 3'd1, 1'b0, 1'b0);
    r(A, 1'b1, 1'b1, 4'h5, 1'b0, 1'b0, 1'b0, 15'h0500, 3'd2, 1'b1, 1'b0);
    r(A, 1'b1, 1'b1, 4'hE, 1'b0, 1'b0, 1'b0, 15'h2002, 3'd0, 1'b0, 1'b0);
    r(A, 1'b1, 1'b1, 4'hE, 1'b0, 1'b0, 1'b0, 15'h0A04, 3'd1, 1'b0, 1'b0);
    r(A, 1'b1, 1'b1, 4'hE, 1'b0, 1'b0, 1'b0, 15'h0088, 3'd2, 1'b1, 1'b0);
    r(A, 1'b1, 1'b1, 4'hA, 1'b0, 1'b0, 1'b0, 15'h2002, 3'd0, 1'b0, 1'b0);
    r(A, 1'b1, 1'b1, 4'hA, 1'b0, 1'b0, 1'b0, 15'h0A04, 3'd1, 1'b1, 1'b0);
    r(A, 1'b1, 1'b1, 4'h4, 1'b0, 1'b0, 1'b0, 15'h2002, 3'd0, 1'b0, 1'b0);
    r(A, 1'b1, 1'b1, 4'h4, 1'b0, 1'b0, 1'b0, 15'h0A04, 3'd1, 1'b0, 1'b0);
    r(A, 1'b1, 1'b1, 4'h4, 1'b0, 1'b0, 1'b0, 15'h2400, 3'd2, 1'b0, 1'b0);
    r(A, 1'b1, 1'b1, 4'h4, 1'b0, 1'b0, 1'b0, 15'h1080, 3'd3, 1'b1, 1'b0);
    r(A, 1'b1, 1'b1, 4'h3, 1'b0, 1'b0, 1'b0, 15'h2002, 3'd0, 1'b0, 1'b0);
    r(A, 1'b1, 1'b1, 4'h3, 1'b0, 1'b0, 1'b0, 15'h0A04, 3'd1, 1'b0, 1'b0);
    r(A, 1'b1, 1'b1, 4'h3, 1'b0, 1'b0, 1'b0, 15'h2400, 3'd2, 1'b0, 1'b0);
    r(A, 1'b1, 1'b1, 4'h3, 1'b0, 1'b0, 1'b0, 15'h0810, 3'd3, 1'b0, 1'b0);
    r(A, 1'b1, 1'b1, 4'h3, 1'b0, 1'b0, 1'b0, 15'h0160, 3'd4, 1'b1, 1'b0);
    // ADD with ena low for three cycles at step 3
    r(A, 1'b1, 1'b1, 4'h2, 1'b0, 1'b0, 1'b0, 15'h2002, 3'd0, 1'b0, 1'b0);
    r(A, 1'b1, 1'b1, 4'h2, 1'b0, 1'b0, 1'b0, 15'h0A04, 3'd1, 1'b0, 1'b0);
    r(A, 1'b1, 1'b1, 4'h2, 1'b0, 1'b0, 1'b0, 15'h2400, 3'd2, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++)
      r(A, 1'b1, 1'b0, 4'h2, 1'b0, 1'b0, 1'b0, 15'h0000, 3'd3, 1'b0, 1'b0);
    r(A, 1'b1, 1'b1, 4'h2, 1'b0, 1'b0, 1'b0, 15'h0810, 3'd3, 1'b0, 1'b0);
    r(A, 1'b1, 1'b1, 4'h2, 1'b0, 1'b0, 1'b0, 15'h0140, 3'd4, 1'b1, 1'b0);
    // ADD interrupted by reset at step 3
    r(A, 1'b1, 1'b1, 4'h2, 1'b0, 1'b0, 1'b0, 15'h2002, 3'd0, 1'b0, 1'b0);
    r(A, 1'b1, 1'b1, 4'h2, 1'b0, 1'b0, 1'b0, 15'h0A04, 3'd1, 1'b0, 1'b0);
    r(A, 1'b1, 1'b1, 4'h2, 1'b0, 1'b0, 1'b0, 15'h2400, 3'd2, 1'b0, 1'b0);
    r(A, 1'b0, 1'b1, 4'h2, 1'b0, 1'b0, 1'b0, 15'h0000, 3'd3, 1'b0, 1'b0);
    // HLT, held ten cycles, resume ignored while disabled, then resume
    r(A, 1'b1, 1'b1, 4'hF, 1'b0, 1'b0, 1'b0, 15'h2002, 3'd0, 1'b0, 1'b0);
    r(A, 1'b1, 1'b1, 4'hF, 1'b0, 1'b0, 1'b0, 15'h0A04, 3'd1, 1'b0, 1'b0);
    r(A, 1'b1, 1'b1, 4'hF, 1'b0, 1'b0, 1'b0, 15'h4000, 3'd2, 1'b1, 1'b0);
    for (int i = 0; i < 10; i++)
      r(A, 1'b1, 1'b1, 4'hF, 1'b0, 1'b0, 1'b0, 15'h4000, 3'd0, 1'b0, 1'b1);
    r(A, 1'b1, 1'b0, 4'hF, 1'b0, 1'b0, 1'b1, 15'h0000, 3'd0, 1'b0, 1'b1);
    r(A, 1'b1, 1'b1, 4'hF, 1'b0, 1'b0, 1'b0, 15'h4000, 3'd0, 1'b0, 1'b1);
    r(A, 1'b1, 1'b1, 4'hF, 1'b0, 1'b0, 1'b1, 15'h4000, 3'd0, 1'b0, 1'b1);
    r(A, 1'b1, 1'b1, 4'h1, 1'b0, 1'b0, 1'b0, 15'h2002, 3'd0, 1'b0, 1'b0);
    r(A, 1'b1, 1'b1, 4'h1, 1'b0, 1'b0, 1'b0, 15'h0A04, 3'd1, 1'b0, 1'b0);
    r(A, 1'b1, 1'b1, 4'h1, 1'b0, 1'b0, 1'b0, 15'h2400, 3'd2, 1'b0, 1'b0);
    r(A, 1'b1, 1'b1, 4'h1, 1'b0, 1'b0, 1'b0, 15'h0900, 3'd3, 1'b1, 1'b0);
    // HLT then reset while halted
    r(A, 1'b1, 1'b1, 4'hF, 1'b0, 1'b0, 1'b0, 15'h2002, 3'd0, 1'b0, 1'b0);
    r(A, 1'b1, 1'b1, 4'hF, 1'b0, 1'b0, 1'b0, 15'h0A04, 3'd1, 1'b0, 1'b0);
    r(A, 1'b1, 1'b1, 4'hF, 1'b0, 1'b0, 1'b0, 15'h4000, 3'd2, 1'b1, 1'b0);
    r(A, 1'b1, 1'b1, 4'hF, 1'b0, 1'b0, 1'b0, 15'h4000, 3'd0, 1'b0, 1'b1);
    r(A, 1'b0, 1'b1, 4'hF, 1'b0, 1'b0, 1'b0, 15'h0000, 3'd0, 1'b0, 1'b1);
    r(A, 1'b1, 1'b1, 4'h1, 1'b0, 1'b0, 1'b0, 15'h2002, 3'd0, 1'b0, 1'b0);

    // Legacy timing instance: reset, SUB, NOP padded to six steps, HLT
    r(N, 1'b0, 1'b1, 4'h3, 1'b0, 1'b0, 1'b0, 15'h0000, 3'd0, 1'b0, 1'b0);
    r(B, 1'b0, 1'b1, 4'h3, 1'b0, 1'b0, 1'b0, 15'h0000, 3'd0, 1'b0, 1'b0);
    r(B, 1'b1, 1'b1, 4'h3, 1'b0, 1'b0, 1'b0, 15'h2002, 3'd0, 1'b0, 1'b0);
    r(B, 1'b1, 1'b1, 4'h3, 1'b0, 1'b0, 1'b0, 15'h0A04, 3'd1, 1'b0, 1'b0);
    r(B, 1'b1, 1'b1, 4'h3, 1'b0, 1'b0, 1'b0, 15'h2400, 3'd2, 1'b0, 1'b0);
    r(B, 1'b1, 1'b1, 4'h3, 1'b0, 1'b0, 1'b0, 15'h0810, 3'd3, 1'b0, 1'b0);
    r(B, 1'b1, 1'b1, 4'h3, 1'b0, 1'b0, 1'b0, 15'h0160, 3'd4, 1'b0, 1'b0);
    r(B, 1'b1, 1'b1, 4'h3, 1'b0, 1'b0, 1'b0, 15'h0000, 3'd5, 1'b1, 1'b0);
    r(B, 1'b1, 1'b1, 4'h0, 1'b0, 1'b0, 1'b0, 15'h2002, 3'd0, 1'b0, 1'b0);
    r(B, 1'b1, 1'b1, 4'h0, 1'b0, 1'b0, 1'b0, 15'h0A04, 3'd1, 1'b0, 1'b0);
    r(B, 1'b1, 1'b1, 4'h0, 1'b0, 1'b0, 1'b0, 15'h0000, 3'd2, 1'b0, 1'b0);
    r(B, 1'b1, 1'b1, 4'h0, 1'b0, 1'b0, 1'b0, 15'h0000, 3'd3, 1'b0, 1'b0);
    r(B, 1'b1, 1'b1, 4'h0, 1'b0, 1'b0, 1'b0, 15'h0000, 3'd4, 1'b0, 1'b0);
    r(B, 1'b1, 1'b1, 4'h0, 1'b0, 1'b0, 1'b0, 15'h0000, 3'd5, 1'b1, 1'b0);
    r(B, 1'b1, 1'b1, 4'hF, 1'b0, 1'b0, 1'b0, 15'h2002, 3'd0, 1'b0, 1'b0);
    r(B, 1'b1, 1'b1, 4'hF, 1'b0, 1'b0, 1'b0, 15'h0A04, 3'd1, 1'b0, 1'b0);
    r(B, 1'b1, 1'b1, 4'hF, 1'b0, 1'b0, 1'b0, 15'h4000, 3'd2, 1'b0, 1'b0);
    r(B, 1'b1, 1'b1, 4'hF, 1'b0, 1'b0, 1'b0, 15'h4000, 3'd0, 1'b0, 1'b1);
    r(B, 1'b1, 1'b1, 4'hF, 1'b0, 1'b0, 1'b1, 15'h4000, 3'd0, 1'b0, 1'b1);
    r(B, 1'b1, 1'b1, 4'h1, 1'b0, 1'b0, 1'b0, 15'h2002, 3'd0, 1'b0, 1'b0);

    @(negedge clk);
    #1;
    n_total = n_total + 1;
    if (sb_q.size() == 0) begin
      n_pass = n_pass + 1;
    end else begin
      $display("FAIL sb_drain: %0d entries left unchecked, want 0", sb_q.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/microseq_ctrl.md
# microseq_ctrl

Parametrised microcode sequencer for the 8-bit CPU. It replaces the fixed-length control block with a T-state counter that can end each instruction early, conditional jumps on the carry and zero flags, a latched halt state with resume, and an enable gate. It sits between the instruction register (`opcode`), the ALU flag register, and the datapath control lines. In the Tiny Tapeout wrapper, `ctrl_out[14:8]` drives `uo_out[6:0]` and `ctrl_out[7:0]` drives `uio_out`.

## Interface
- `T_STATES`, default 6. Maximum microsteps per instruction, fetch included. Legal range is 5..8.
- `EARLY_END`, default 1. 1: wrap to step 0 after an instruction's last microstep. 0: always run all `T_STATES` steps (legacy timing).
- `STEP_W`, derived as clog2(`T_STATES`). Not user-set.
- `clk`  in  1  Single clock; all state changes on the rising edge.
- `rst_n`  in  1  Synchronous, active-low reset.
- `ena`  in  1  High: sequencer advances. Low: all state holds and `ctrl_out` = 0.
- `opcode`  in  4  Instruction register high nibble. Valid from step 2 onward.
- `flag_c`  in  1  Carry flag, used by JC at step 2.
- `flag_z`  in  1  Zero flag, used by JZ at step 2.
- `resume`  in  1  Leave HALTED on the next edge.
- `ctrl_out`  out  15  Control word. Bit map: 14 HLT, 13 MI, 12 RI, 11 RO, 10 IO, 9 II, 8 AI, 7 AO, 6 EO, 5 SU, 4 BI, 3 OI, 2 CE, 1 CO, 0 J.
- `step`  out  STEP_W  Current microstep.
- `instr_done`  out  1  High during the last microstep of an instruction.
- `halted`  out  1  High in the HALTED state.

## Operation
- States are RUN and HALTED. Reset enters RUN with `step` = 0.
- Fetch steps, independent of opcode:
  - step 0: MI|CO = 0x2002
  - step 1: RO|II|CE = 0x0A04
- Execute steps (step.word), followed by instruction length in steps:
  - 0 NOP: no execute steps; length 2.
  - 1 LDA: 2.0x2400, 3.0x0900; length 4.
  - 2 ADD: 2.0x2400, 3.0x0810, 4.0x0140; length 5.
  - 3 SUB: as ADD except 4.0x0160; length 5.
  - 4 STA: 2.0x2400, 3.0x1080; length 4.
  - 5 LDI: 2.0x0500; length 3.
  - 6 JMP: 2.0x0401; length 3.
  - 7 JC: 2.0x0401 if `flag_c`, else 0x0000; length 3.
  - 8 JZ: 2.0x0401 if `flag_z`, else 0x0000; length 3.
  - E OUT: 2.0x0088; length 3.
  - F HLT: 2.0x4000; length 3.
  - 9–D: treated as NOP.
- Steps beyond an instruction's length output 0x0000. These steps occur only when `EARLY_END` = 0.
- Step advance in RUN with `ena` = 1:
  - If `instr_done` is high, the next `step` is 0.
  - Otherwise `step` increments.
  - `instr_done` = (`step` == length−1) when `EARLY_END` = 1, else (`step` == `T_STATES`−1).
- HLT handling:
  - At HLT step 2 the edge moves the state to HALTED regardless of `EARLY_END`, with `step` = 0.
  - In HALTED: `ctrl_out` = 0x4000, `halted` = 1, `instr_done` = 0, `step` = 0.
  - `resume` = 1 with `ena` = 1 moves to RUN, step 0, on the next edge.
- `resume` in RUN is ignored.
- `ena` = 0 overrides everything except reset: state and `step` hold, `ctrl_out` = 0, `instr_done` = 0, and `halted` reflects the held state.

## Timing
- Reset:
  - While `rst_n` = 0: `ctrl_out` = 0, `instr_done` = 0.
  - After the reset edge: `step` = 0, `halted` = 0, state RUN.
  - The first cycle after `rst_n` rises outputs 0x2002.
- Outputs are combinational from registered `step`/state plus `opcode`, `flag_c` and `flag_z`. There is no added latency: the word for step n is valid throughout the cycle in which `step` = n.
- Flags are sampled combinationally during step 2 only. A flag change mid-cycle must settle before the edge.
- Reset takes priority over `ena` and `resume`. Reset mid-instruction or in HALTED returns to RUN, step 0 on that edge.
- `step` never exceeds `T_STATES`−1. With `EARLY_END` = 0 the longest instruction (5 steps) still fits, since `T_STATES` ≥ 5.

## Test plan
- Reset, then LDA (opcode 1), `EARLY_END` = 1 → `ctrl_out` sequence 0x2002, 0x0A04, 0x2400, 0x0900, 0x2002. `instr_done` is high only at step 3.
- SUB with `EARLY_END` = 0, `T_STATES` = 6 → 0x2002, 0x0A04, 0x2400, 0x0810, 0x0160, 0x0000, then 0x2002. `instr_done` is high at step 5.
- JC with `flag_c` = 0 → step 2 = 0x0000, wrap after 3 steps. Repeat with `flag_c` = 1 → step 2 = 0x0401. Repeat both with JZ/`flag_z`.
- HLT → step 2 = 0x4000, then `halted` = 1 and `ctrl_out` = 0x4000 held for 10 cycles. Pulse `resume` → next cycle `halted` = 0, `ctrl_out` = 0x2002.
- ADD with `ena` dropped for 3 cycles at step 3 → `ctrl_out` = 0 and `step` = 3 held. On re-enable, 0x0810 then 0x0140 resume without a skipped step.
- `rst_n` low for one edge at ADD step 3 → the next cycle shows step 0 and 0x2002. Repeat with `rst_n` low in HALTED → `halted` clears.
